// File: rtl/stream_ram_if.sv
// stream_ram_if: rx/tx valid-ready streams plus status flags of stream_ram
interface stream_ram_if #(parameter int DATA_W = 8);
   logic [DATA_W-1:0] rx_data_i;
   logic              rx_valid_i;
   logic              rx_ready_o;
   logic [DATA_W-1:0] tx_data_o;
   logic              tx_valid_o;
   logic              tx_ready_i;
   logic              busy_o;
   logic              err_o;
   modport master (
      output rx_data_i, rx_valid_i, tx_ready_i,
      input  rx_ready_o, tx_data_o, tx_valid_o, busy_o, err_o
   );
   modport slave (
      input  rx_data_i, rx_valid_i, tx_ready_i,
      output rx_ready_o, tx_data_o, tx_valid_o, busy_o, err_o
   );
endinterface

// File: rtl/stream_ram.sv
// stream_ram: command-driven scratch word memory between a stream source and sink
module stream_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input logic         clk_i,
   input logic         rst_i,
   stream_ram_if.slave s
);
   typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ADDR, S_WLEN, S_WDATA, S_RLEN, S_RDATA} state_t;
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);
   localparam logic [DATA_W:0]   LP_DEPTH = (DATA_W + 1)'(DEPTH);
   state_t            r_state, w_state_nxt, w_op_state;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_ptr, r_addr, w_addr_nxt;
   logic [DATA_W-1:0] r_cnt, r_tx_data;
   logic              r_tx_valid, r_err;
   logic              w_rx_ready, w_rx_fire, w_tx_fire, w_cmd_ok, w_addr_ok, w_len_zero, w_last;
   assign w_rx_fire  = s.rx_valid_i && w_rx_ready;
   assign w_tx_fire  = r_tx_valid && s.tx_ready_i;
   assign w_cmd_ok   = s.rx_data_i[DATA_W-1:2] == '0;
   assign w_addr_ok  = {1'b0, s.rx_data_i} < LP_DEPTH;
   assign w_len_zero = s.rx_data_i == '0;
   assign w_addr_nxt = (r_addr == LP_LAST) ? '0 : r_addr + ADDR_W'(1);
   assign w_op_state = s.rx_data_i[1] ? (s.rx_data_i[0] ? S_RLEN : S_WLEN)
                                      : (s.rx_data_i[0] ? S_ADDR : S_CLEAR);
   // in RDATA r_cnt counts words still to be loaded behind the one on tx
   assign w_last = r_cnt == '0;
   always_ff @(posedge clk_i)
      r_state <= rst_i ? S_CLEAR : w_state_nxt;
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_CLEAR: w_state_nxt = (r_ptr == LP_LAST) ? S_IDLE : S_CLEAR;
         S_IDLE:  if (w_rx_fire && w_cmd_ok) w_state_nxt = w_op_state;
         S_ADDR:  if (w_rx_fire) w_state_nxt = S_IDLE;
         S_WLEN:  if (w_rx_fire) w_state_nxt = w_len_zero ? S_IDLE : S_WDATA;
         S_WDATA: if (w_rx_fire && r_cnt == DATA_W'(1)) w_state_nxt = S_IDLE;
         S_RLEN:  if (w_rx_fire) w_state_nxt = w_len_zero ? S_IDLE : S_RDATA;
         S_RDATA: if (w_tx_fire && w_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end
   always_comb begin
      w_rx_ready = r_state inside {S_IDLE, S_ADDR, S_WLEN, S_WDATA, S_RLEN};
      s.busy_o   = r_state != S_IDLE;
   end
   assign s.rx_ready_o = w_rx_ready;
   assign s.tx_data_o  = r_tx_data;
   assign s.tx_valid_o = r_tx_valid;
   assign s.err_o      = r_err;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr      <= '0;
         r_addr     <= '0;
         r_cnt      <= '0;
         r_err      <= 1'b0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         case (r_state)
            S_CLEAR: r_ptr <= (r_ptr == LP_LAST) ? '0 : r_ptr + ADDR_W'(1);
            S_IDLE: if (w_rx_fire) begin
               if (!w_cmd_ok) r_err <= 1'b1;
               else if (w_op_state == S_CLEAR) begin
                  r_ptr  <= '0;
                  r_addr <= '0;
               end
            end
            S_ADDR: if (w_rx_fire) begin
               if (w_addr_ok) r_addr <= s.rx_data_i[ADDR_W-1:0];
               else r_err <= 1'b1;
            end
            S_WLEN: if (w_rx_fire) r_cnt <= s.rx_data_i;
            S_WDATA: if (w_rx_fire) begin
               r_addr <= w_addr_nxt;
               r_cnt  <= r_cnt - DATA_W'(1);
            end
            // first word is loaded together with the length so tx is valid next cycle
            S_RLEN: if (w_rx_fire && !w_len_zero) begin
               r_tx_data  <= r_mem[r_addr];
               r_tx_valid <= 1'b1;
               r_addr     <= w_addr_nxt;
               r_cnt      <= s.rx_data_i - DATA_W'(1);
            end
            S_RDATA: if (w_tx_fire) begin
               if (w_last) r_tx_valid <= 1'b0;
               else begin
                  r_tx_data <= r_mem[r_addr];
                  r_addr    <= w_addr_nxt;
                  r_cnt     <= r_cnt - DATA_W'(1);
               end
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk_i)
      if (!rst_i && r_state == S_CLEAR) r_mem[r_ptr] <= '0;
      else if (!rst_i && r_state == S_WDATA && w_rx_fire) r_mem[r_addr] <= s.rx_data_i;
endmodule

// File: tb/tb_stream_ram.sv
// tb_stream_ram: DEPTH=16 and DEPTH=10 instances fed the same stream, checked against array models
module tb_stream_ram;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   logic [7:0] m16 [16];
   logic [7:0] m10 [10];
   int   a16, a10;
   bit   e16, e10;
   logic [7:0] q [$];
   always #5 clk = ~clk;
   stream_ram_if #(.DATA_W(8)) b16 ();
   stream_ram_if #(.DATA_W(8)) b10 ();
   assign b10.rx_data_i  = b16.rx_data_i;
   assign b10.rx_valid_i = b16.rx_valid_i;
   assign b10.tx_ready_i = b16.tx_ready_i;
   stream_ram #(.DATA_W(8), .DEPTH(16)) u_dut16 (.clk_i(clk), .rst_i(rst), .s(b16));
   stream_ram #(.DATA_W(8), .DEPTH(10)) u_dut10 (.clk_i(clk), .rst_i(rst), .s(b10));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic chk_status();
      chk("err16", 32'(b16.err_o), 32'(e16));
      chk("err10", 32'(b10.err_o), 32'(e10));
      chk("busy16", 32'(b16.busy_o), 0);
      chk("busy10", 32'(b10.busy_o), 0);
   endtask
   task automatic model_clear();
      foreach (m16[i]) m16[i] = 8'h00;
      foreach (m10[i]) m10[i] = 8'h00;
      a16 = 0;
      a10 = 0;
   endtask
   task automatic sweep();
      int c16 = 0;
      int c10 = 0;
      for (int i = 0; i < 40; i++) begin
         if (b16.rx_ready_o && b10.rx_ready_o) break;
         if (!b16.rx_ready_o) c16++;
         if (!b10.rx_ready_o) c10++;
         @(negedge clk);
      end
      chk("sweep16", 32'(c16), 16);
      chk("sweep10", 32'(c10), 10);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      b16.rx_valid_i = 1'b0;
      b16.tx_ready_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("rst rx_ready", 32'(b16.rx_ready_o), 0);
      chk("rst busy", 32'(b16.busy_o), 1);
      chk("rst tx_valid16", 32'(b16.tx_valid_o), 0);
      chk("rst tx_valid10", 32'(b10.tx_valid_o), 0);
      chk("rst err", 32'(b16.err_o), 0);
      model_clear();
      e16 = 1'b0;
      e10 = 1'b0;
      sweep();
      chk_status();
   endtask
   task automatic send(input logic [7:0] w);
      int t = 0;
      while (!b16.rx_ready_o && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t == 100) chk("rx_ready timeout", 32'(b16.rx_ready_o), 1);
      b16.rx_data_i  = w;
      b16.rx_valid_i = 1'b1;
      @(negedge clk);
      b16.rx_valid_i = 1'b0;
   endtask
   // mode 0: sink always ready, 1: ready pattern 1,0,0,..., 2: random ready
   task automatic get_words(input int n, input int mode, input bit fin);
      int   got = 0;
      int   t = 0;
      logic rdy;
      if (mode != 0) begin
         b16.rx_data_i  = 8'h01;
         b16.rx_valid_i = 1'b1;
      end
      while (got < n && t < 8 * n + 20) begin
         chk("tx_valid16", 32'(b16.tx_valid_o), 1);
         chk("tx_valid10", 32'(b10.tx_valid_o), 1);
         chk("rx_ready in read", 32'(b16.rx_ready_o), 0);
         chk("tx_data16", 32'(b16.tx_data_o), 32'(m16[a16]));
         chk("tx_data10", 32'(b10.tx_data_o), 32'(m10[a10]));
         rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 3 == 0) : 1'($urandom_range(0, 1));
         b16.tx_ready_i = rdy;
         if (rdy) begin
            got++;
            a16 = (a16 + 1) % 16;
            a10 = (a10 + 1) % 10;
         end
         @(negedge clk);
         t++;
      end
      b16.rx_valid_i = 1'b0;
      b16.tx_ready_i = 1'b0;
      if (got < n) chk("read timeout", 32'(got), 32'(n));
      if (fin) begin
         chk("tx_valid16 end", 32'(b16.tx_valid_o), 0);
         chk("tx_valid10 end", 32'(b10.tx_valid_o), 0);
         chk("rx_ready end", 32'(b16.rx_ready_o), 1);
         chk_status();
      end
   endtask
   task automatic cmd_set(input logic [7:0] v);
      send(8'h01);
      send(v);
      if (v < 16) a16 = int'(v); else e16 = 1'b1;
      if (v < 10) a10 = int'(v); else e10 = 1'b1;
      chk_status();
   endtask
   task automatic cmd_write(input logic [7:0] d [$]);
      send(8'h02);
      send(8'(d.size()));
      foreach (d[i]) begin
         send(d[i]);
         m16[a16] = d[i];
         m10[a10] = d[i];
         a16 = (a16 + 1) % 16;
         a10 = (a10 + 1) % 10;
      end
      chk_status();
   endtask
   task automatic cmd_read(input int n, input int mode);
      send(8'h03);
      send(8'(n));
      if (n == 0) chk_status();
      else get_words(n, mode, 1'b1);
   endtask
   task automatic cmd_bad(input logic [7:0] v);
      send(v);
      e16 = 1'b1;
      e10 = 1'b1;
      chk_status();
   endtask
   task automatic cmd_clear();
      send(8'h00);
      model_clear();
      sweep();
      chk_status();
   endtask
   initial begin
      b16.rx_data_i  = 8'h00;
      b16.rx_valid_i = 1'b0;
      b16.tx_ready_i = 1'b0;
      do_reset();
      cmd_read(16, 0);
      cmd_set(8'd3);
      q = {8'hA1, 8'hB2, 8'hC3};
      cmd_write(q);
      cmd_set(8'd3);
      cmd_read(3, 0);
      cmd_set(8'd15);
      q = {8'h11, 8'h22};
      cmd_write(q);
      cmd_set(8'd15);
      cmd_read(2, 0);
      cmd_set(8'd9);
      q = {8'h33, 8'h44};
      cmd_write(q);
      cmd_set(8'd9);
      cmd_read(2, 0);
      cmd_set(8'd0);
      cmd_read(1, 0);
      cmd_set(8'd0);
      cmd_read(4, 1);
      cmd_bad(8'h04);
      cmd_set(8'd3);
      cmd_set(8'd20);
      cmd_read(1, 0);
      send(8'h02);
      send(8'h00);
      chk_status();
      cmd_set(8'd3);
      cmd_read(3, 0);
      cmd_clear();
      cmd_read(16, 0);
      for (int k = 0; k < 25; k++) begin
         case ($urandom_range(0, 4))
            0: cmd_set(8'($urandom_range(0, 19)));
            1, 2: begin
               q.delete();
               repeat ($urandom_range(1, 20)) q.push_back(8'($urandom));
               cmd_write(q);
            end
            3: cmd_read($urandom_range(1, 20), 2);
            default: cmd_bad(8'($urandom_range(4, 255)));
         endcase
      end
      cmd_set(8'd0);
      send(8'h03);
      send(8'd5);
      get_words(2, 0, 1'b0);
      do_reset();
      cmd_read(16, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/stream_ram.md
# stream_ram

Parametrised, command-driven word memory on a byte/word stream. It replaces fixed-size, in-band-toggled storage with explicit opcodes, settable addresses, length-counted bursts and valid/ready flow control in both directions. It sits between a stream source (UART/SPI receiver) and a stream sink (transmitter), acting as a scratch buffer the host can clear, fill and read back.

## Interface
- DATA_W, 8, word width; must be ≥ 2 and ≥ ADDR_W
- DEPTH, 16, number of words; any value ≥ 2, not required to be a power of two
- ADDR_W, $clog2(DEPTH), derived; do not override
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- rx_data_i  in  DATA_W  command/operand/write-data word
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  block accepts rx word this cycle
- tx_data_o  out  DATA_W  read-data word
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  sink accepts tx word
- busy_o  out  1  state ≠ IDLE
- err_o  out  1  sticky protocol error flag

## Operation
- Storage: register array mem[0:DEPTH-1], DATA_W wide; address pointer addr (ADDR_W bits); burst counter cnt (DATA_W bits).
- rx transfer when rx_valid_i && rx_ready_o; tx transfer when tx_valid_o && tx_ready_i.
- Command word (in IDLE): opcode = rx_data_i[1:0]; rx_data_i[DATA_W-1:2] must be 0, otherwise err_o ← 1, word discarded, stay IDLE.
  - 0 CLEAR: go to CLEAR, ptr ← 0, addr ← 0.
  - 1 SET_ADDR: go to ADDR; next rx word is the address.
  - 2 WRITE: go to WLEN; next rx word is length N.
  - 3 READ: go to RLEN; next rx word is length N.
- States: CLEAR, IDLE, ADDR, WLEN, WDATA, RLEN, RDATA.
  - CLEAR: mem[ptr] ← 0 each cycle, ptr++; after ptr = DEPTH-1 cleared → IDLE. rx_ready_o = 0.
  - ADDR: value < DEPTH → addr ← value; value ≥ DEPTH → err_o ← 1, addr unchanged. → IDLE.
  - WLEN / RLEN: N = 0 → IDLE (no transfer); else cnt ← N, → WDATA / RDATA.
  - WDATA: each accepted word → mem[addr], addr ← (addr = DEPTH-1) ? 0 : addr+1, cnt--; cnt reaching 0 → IDLE.
  - RDATA: rx_ready_o = 0; emits N words mem[addr], mem[addr+1]…, same wrap rule; after last tx transfer → IDLE.
- rx_ready_o = 1 in IDLE, ADDR, WLEN, WDATA, RLEN; 0 in CLEAR, RDATA.
- addr persists across commands; a READ after a WRITE of N words must be preceded by SET_ADDR to re-read them.
- err_o only cleared by rst_i; block keeps operating after error.

## Timing
- Reset (rst_i sampled high): state ← CLEAR, ptr ← 0, addr ← 0, cnt ← 0, err_o ← 0, tx_valid_o ← 0, tx_data_o ← 0. Outputs during/after reset edge: rx_ready_o 0, busy_o 1.
- Reset sweep: DEPTH clock edges with rst_i low clear mem[0..DEPTH-1]; rx_ready_o rises after the DEPTH-th such edge. CLEAR command takes identical DEPTH cycles.
- rst_i mid-operation always wins: burst aborted, tx_valid_o low the following cycle, sweep restarts.
- Write latency: word accepted at edge k is in mem at edge k; readable by any later READ.
- Read: first tx_valid_o asserts the cycle after the length word is accepted. tx_data_o is registered, loaded from mem[addr] when (!tx_valid_o || tx_ready_i) and words remain. With tx_ready_i held high: one word per cycle, N words in N cycles.
- tx_data_o and tx_valid_o stable while tx_valid_o && !tx_ready_i.
- After the final tx transfer: tx_valid_o low next cycle, state IDLE, rx_ready_o high same cycle.
- N counts 1..2^DATA_W-1; bursts longer than DEPTH wrap and overwrite/re-read.

## Test plan
- Reset, DEPTH=16: rst_i 1 cycle → rx_ready_o low exactly 16 cycles then high; READ len 16 from addr 0 returns sixteen 0x00, err_o 0.
- SET_ADDR 3, WRITE len 3 {0xA1,0xB2,0xC3}, SET_ADDR 3, READ len 3 with tx_ready_i=1 → 0xA1,0xB2,0xC3 on consecutive cycles, busy_o low after.
- Wrap: SET_ADDR 15, WRITE len 2 {0x11,0x22}; SET_ADDR 15, READ len 2 → 0x11 then 0x22 (mem[0]); repeat with DEPTH=10 and addr 9 → same wrap to 0.
- Backpressure: READ len 4 with tx_ready_i toggling 1,0,0,1… → each word held stable while stalled, no word lost or duplicated; rx_valid_i asserted during RDATA is not accepted.
- Errors: command 0x04 → err_o 1, state IDLE; SET_ADDR 20 with DEPTH=16 → err_o 1, addr unchanged; WRITE len 0 → immediate IDLE, no memory change.
- Reset mid-READ (after 2 of 5 words): tx_valid_o low next cycle, err_o 0, memory all zero after 16-cycle sweep.
